// File: rtl/axis_arb_pkg.sv
// Shared constants, types and helpers for the AXI-Stream switch arbiter.
package axis_arb_pkg;

  localparam int NUM_SRC = 3;
  localparam int GID_W   = 2;
  localparam logic [GID_W-1:0] GID_NONE = 2'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [NUM_SRC-1:0] mask;
    logic               force_en;
    logic [GID_W-1:0]   force_sel;
  } arb_cfg_t;

  function automatic logic [NUM_SRC-1:0] gid_onehot(input logic [GID_W-1:0] id);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id == GID_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/axis_arb_rr_pick.sv
// Combinational round-robin picker: first eligible source strictly after rr_ptr.
module axis_arb_rr_pick
  import axis_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [GID_W-1:0]   rr_ptr,
  output logic [GID_W-1:0]   pick_id,
  output logic               pick_vld
);

  logic [GID_W-1:0] idx;

  // Scan farthest-first so the nearest candidate after rr_ptr overwrites the rest.
  always_comb begin
    pick_id  = GID_NONE;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = GID_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (eligible[idx]) begin
        pick_id  = idx;
        pick_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_switch_arbiter.sv
// Packet-granular 3-source AXI-Stream switch arbiter with fixed-grant override.
// Optional grant watchdog enabled by defining AXIS_ARB_TIMEOUT_EN.
module axis_switch_arbiter
  import axis_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_SRC-1:0]   s_req,
  input  logic [NUM_SRC-1:0]   src_mask,
  input  logic                 force_en,
  input  logic [GID_W-1:0]     force_sel,
  input  logic                 m_tvalid,
  input  logic                 m_tready,
  input  logic                 m_tlast,
  output logic                 s0_en,
  output logic                 s1_en,
  output logic                 s2_en,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_cnt0,
  output logic [CNT_W-1:0]     pkt_cnt1,
  output logic [CNT_W-1:0]     pkt_cnt2,
  output logic                 timeout_err
);

  // Assert asynchronously, release on aclk after two flops.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  arb_cfg_t cfg;
  assign cfg = '{mask: src_mask, force_en: force_en, force_sel: force_sel};

  arb_state_e                      state_q, state_d;
  logic [NUM_SRC-1:0]              s_en_q, s_en_d;
  logic [GID_W-1:0]                grant_id_q, grant_id_d;
  logic                            busy_q, busy_d;
  logic [GID_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0][CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic [NUM_SRC-1:0] eligible;
  logic [GID_W-1:0]   pick_id;
  logic               pick_vld;
  logic               beat, last_beat;
  logic               req_vld;
  logic [GID_W-1:0]   req_id;
  logic               rel;

  assign eligible  = s_req & ~cfg.mask;
  assign beat      = m_tvalid & m_tready;
  assign last_beat = beat & m_tlast;

  axis_arb_rr_pick u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .pick_id  (pick_id),
    .pick_vld (pick_vld)
  );

`ifdef AXIS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_expire;
  logic            timeout_err_q, timeout_err_d;

  // A cycle with any accepted beat never expires, so a tlast beat always wins.
  assign wd_expire = (state_q == GRANT) && !beat && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d = '0;
    if ((state_q == GRANT) && !beat && !wd_expire) wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    s_en_d     = s_en_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    req_vld    = 1'b0;
    req_id     = GID_NONE;
    rel        = 1'b0;
`ifdef AXIS_ARB_TIMEOUT_EN
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Forced grant ignores requests and mask; force_sel==GID_NONE parks the switch.
        if (cfg.force_en) begin
          req_vld = (cfg.force_sel != GID_NONE);
          req_id  = cfg.force_sel;
        end else begin
          req_vld = pick_vld;
          req_id  = pick_id;
        end
        if (req_vld) begin
          state_d    = GRANT;
          s_en_d     = gid_onehot(req_id);
          grant_id_d = req_id;
          busy_d     = 1'b1;
        end
      end
      GRANT: begin
        if (last_beat) begin
          rel = 1'b1;
          for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id_q == GID_W'(i)) pkt_cnt_d[i] = pkt_cnt_q[i] + CNT_W'(1);
          end
        end
`ifdef AXIS_ARB_TIMEOUT_EN
        else if (wd_expire) begin
          rel           = 1'b1;
          timeout_err_d = 1'b1;
        end
`endif
        if (rel) begin
          state_d    = IDLE;
          s_en_d     = '0;
          grant_id_d = GID_NONE;
          busy_d     = 1'b0;
          rr_ptr_d   = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rr_ptr resets to the last source so source 0 wins the first arbitration.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_en_q     <= '0;
      grant_id_q <= GID_NONE;
      busy_q     <= 1'b0;
      rr_ptr_q   <= GID_W'(NUM_SRC - 1);
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      s_en_q     <= s_en_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign {s2_en, s1_en, s0_en} = s_en_q;
  assign grant_id              = grant_id_q;
  assign busy                  = busy_q;
  assign pkt_cnt0              = pkt_cnt_q[0];
  assign pkt_cnt1              = pkt_cnt_q[1];
  assign pkt_cnt2              = pkt_cnt_q[2];

endmodule

// File: tb/tb_axis_switch_arbiter.sv
// Scoreboard bench for axis_switch_arbiter: grant order checked by a monitor, counters by directed checks.
module tb_axis_switch_arbiter;

  localparam int CW   = 3;
  localparam int TCYC = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic [2:0]    s_req = '0;
  logic [2:0]    src_mask = '0;
  logic          force_en = 1'b0;
  logic [1:0]    force_sel = '0;
  logic          m_tvalid = 1'b0, m_tready = 1'b0, m_tlast = 1'b0;
  logic          s0_en, s1_en, s2_en;
  logic [1:0]    grant_id;
  logic          busy;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1, pkt_cnt2;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  logic prev_busy = 1'b0;

  axis_switch_arbiter #(.TIMEOUT_CYC(TCYC), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_req(s_req), .src_mask(src_mask),
    .force_en(force_en), .force_sel(force_sel),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .s0_en(s0_en), .s1_en(s1_en), .s2_en(s2_en), .grant_id(grant_id), .busy(busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2),
    .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: invariants every cycle, grant order popped on each new grant.
  always @(negedge aclk) begin
    logic [2:0] en;
    int e;
    en = {s2_en, s1_en, s0_en};
    check("onehot", 32'($countones(en) <= 1), 1);
    check("gid_match", busy ? 32'(en == (3'b001 << grant_id)) : 32'(grant_id == 2'd3 && en == 3'b000), 1);
    if (busy && !prev_busy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant: got id %0d want no grant", grant_id);
      end else begin
        e = exp_q.pop_front();
        check("grant_order", grant_id, e);
        check("grant_en", en, 32'(3'b001 << e));
      end
    end
    prev_busy <= busy;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (!busy && n < 40) begin
      tick();
      n++;
    end
    if (!busy) begin
      total++;
      bad++;
      $display("FAIL %s: busy=0 want 1 within 40 cycles", name);
    end
  endtask

  task automatic beats(input int n);
    for (int b = 0; b < n; b++) begin
      m_tvalid = 1'b1;
      m_tready = 1'b1;
      m_tlast  = (b == n - 1);
      tick();
    end
    m_tvalid = 1'b0;
    m_tready = 1'b0;
    m_tlast  = 1'b0;
  endtask

  task automatic check_cnts(input string name, input int c0, input int c1, input int c2);
    check({name, "_cnt0"}, pkt_cnt0, c0);
    check({name, "_cnt1"}, pkt_cnt1, c1);
    check({name, "_cnt2"}, pkt_cnt2, c2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    #2 aresetn = 1'b0;
    #20;
    check("rst_en", {s2_en, s1_en, s0_en}, 0);
    check("rst_gid", grant_id, 3);
    check("rst_busy", busy, 0);
    check("rst_tmo", timeout_err, 0);
    check_cnts("rst", 0, 0, 0);

    // Round robin from reset: 0, 1, 2, 0
    @(posedge aclk); #1;
    s_req = 3'b111;
    aresetn = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
    for (int p = 0; p < 4; p++) begin
      wait_grant("rr_grant");
      if (p == 3) s_req = 3'b000;
      beats(4);
      check("rr_gap", busy, 0);
    end
    check_cnts("rr", 2, 1, 1);

    // Masked source 1; rr_ptr=0 so order is 2, 0, 2, 0
    src_mask = 3'b010;
    s_req = 3'b111;
    exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0);
    for (int p = 0; p < 4; p++) begin
      wait_grant("mask_grant");
      if (p == 3) s_req = 3'b000;
      beats(2);
    end
    src_mask = 3'b000;
    check_cnts("mask", 4, 1, 3);

    // Force applied mid-packet on source 0; request dropped mid-packet
    s_req = 3'b001;
    exp_q.push_back(0); exp_q.push_back(2);
    wait_grant("force_pre");
    force_en = 1'b1;
    force_sel = 2'd2;
    s_req = 3'b000;
    tick();
    check("drop_req_hold", {s2_en, s1_en, s0_en}, 3'b001);
    beats(4);
    check("force_gap", busy, 0);
    tick();
    check("force_grant", {s2_en, s1_en, s0_en}, 3'b100);
    beats(4);
    force_sel = 2'd3;
    s_req = 3'b111;
    tick(); tick(); tick();
    check("force_none_idle", busy, 0);
    s_req = 3'b000;
    force_en = 1'b0;
    tick();
    check_cnts("force", 5, 1, 4);

    // Source 1 stalled 10 cycles, then single tlast beat; rr_ptr=2 so 1 wins
    s_req = 3'b010;
    exp_q.push_back(1); exp_q.push_back(0);
    wait_grant("stall_grant");
    s_req = 3'b001;
    m_tvalid = 1'b1;
    m_tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_hold", {s2_en, s1_en, s0_en}, 3'b010);
    end
    beats(1);
    check("stall_gap", busy, 0);
    check("stall_cnt1", pkt_cnt1, 2);
    tick();
    check("post_stall_grant", {s2_en, s1_en, s0_en}, 3'b001);
    s_req = 3'b000;
    beats(4);
    check_cnts("stall", 6, 2, 4);

    // Reset mid-packet on source 2 (rr_ptr=0)
    s_req = 3'b100;
    exp_q.push_back(2);
    wait_grant("rst_mid_grant");
    s_req = 3'b000;
    m_tvalid = 1'b1; m_tready = 1'b1; m_tlast = 1'b0;
    tick(); tick();
    m_tvalid = 1'b0; m_tready = 1'b0;
    aresetn = 1'b0;
    #1;
    check("rst_mid_en", {s2_en, s1_en, s0_en}, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_gid", grant_id, 3);
    check_cnts("rst_mid", 0, 0, 0);
    @(posedge aclk); #1;
    s_req = 3'b111;
    aresetn = 1'b1;
    exp_q.push_back(0);
    wait_grant("rst_rel_grant");
    s_req = 3'b000;
    beats(4);
    check_cnts("rst_rel", 1, 0, 0);

    // Counter wrap: seven more source-0 packets take 1 -> 0 through 7
    s_req = 3'b001;
    for (int p = 0; p < 7; p++) begin
      exp_q.push_back(0);
      wait_grant("wrap_grant");
      if (p == 6) s_req = 3'b000;
      beats(1);
      if (p == 5) check("wrap_max", pkt_cnt0, 7);
    end
    check("wrap_zero", pkt_cnt0, 0);

`ifdef AXIS_ARB_TIMEOUT_EN
    // Watchdog: 8 stalled cycles release without counting; rr_ptr=0 so 1 wins
    s_req = 3'b010;
    exp_q.push_back(1);
    wait_grant("tmo_grant");
    s_req = 3'b000;
    for (int c = 0; c < TCYC - 1; c++) begin
      tick();
      check("tmo_pre_busy", busy, 1);
      check("tmo_pre_err", timeout_err, 0);
    end
    tick();
    check("tmo_pulse", timeout_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_en", {s2_en, s1_en, s0_en}, 0);
    check("tmo_cnt1", pkt_cnt1, 0);
    tick();
    check("tmo_single", timeout_err, 0);

    // tlast beat on the 8th stalled cycle wins over the watchdog
    s_req = 3'b010;
    exp_q.push_back(1);
    wait_grant("tmo_tlast_grant");
    s_req = 3'b000;
    for (int c = 0; c < TCYC - 1; c++) tick();
    beats(1);
    check("tlast_wins_err", timeout_err, 0);
    check("tlast_wins_busy", busy, 0);
    check("tlast_wins_cnt1", pkt_cnt1, 1);
    tick();
    check("tlast_wins_after", timeout_err, 0);
`else
    check("tmo_tied", timeout_err, 0);
`endif

    tick(); tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_switch_arbiter.md
AXIS_SWITCH_ARBITER -- requirements
Module: axis_switch_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, meaning idle-beat cycles before a forced grant release (used only under AXIS_ARB_TIMEOUT_EN).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the per-source packet counters.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 aclk  in  1  sole clock, all logic rising-edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 s_req  in  3  per-source s{0,1,2}_axis_tvalid, bit i = source i.
REQ-007 src_mask  in  3  config: bit i = 1 makes source i ineligible.
REQ-008 force_en  in  1  config: fixed-grant mode.
REQ-009 force_sel  in  2  config: source granted when force_en=1; value 3 = no grant.
REQ-010 m_tvalid, m_tready, m_tlast  in  1 each  switch output handshake monitor.
REQ-011 s0_en, s1_en, s2_en  out  1 each  one-hot (or all-zero) switch enables.
REQ-012 grant_id  out  2  current grant; 3 when none.
REQ-013 busy  out  1  high while a grant is held.
REQ-014 pkt_cnt0, pkt_cnt1, pkt_cnt2  out  CNT_W each  completed-packet count per source.
REQ-015 timeout_err  out  1  single-cycle pulse on watchdog release (tied 0 without the macro).

Function
REQ-016 SHALL implement states IDLE and GRANT; all outputs SHALL be registered.
REQ-017 In IDLE, eligible = s_req & ~src_mask; if force_en=0 and eligible nonzero, SHALL grant the first eligible source after rr_ptr (circular 0->1->2->0) and enter GRANT at the same edge.
REQ-018 In IDLE with force_en=1 and force_sel<3, SHALL grant force_sel at the next edge regardless of s_req/src_mask; force_sel=3 SHALL hold IDLE.
REQ-019 Grant latency SHALL be one cycle: request seen at edge N -> sN_en high from edge N+1.
REQ-020 In GRANT, the enables SHALL remain constant until a beat (m_tvalid & m_tready & m_tlast) is accepted; at that edge, state -> IDLE, enables -> 0, rr_ptr -> granted id, granted pkt_cnt += 1.
REQ-021 The minimum gap between packets SHALL be one IDLE cycle; re-arbitration happens in that cycle.
REQ-022 Changes to src_mask, force_en or force_sel during GRANT SHALL take effect only at the next IDLE arbitration, never mid-packet.
REQ-023 A granted source dropping s_req mid-packet SHALL NOT release the grant.
REQ-024 At most one sN_en SHALL be high in any cycle; grant_id SHALL match the asserted enable.
REQ-025 pkt_cnt SHALL wrap from 2^CNT_W-1 to 0 silently.

Reset
REQ-026 aresetn low SHALL immediately force state=IDLE, all sN_en=0, grant_id=3, busy=0, rr_ptr=2 (so source 0 wins first), pkt_cnt*=0, timeout_err=0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet without incrementing any counter; reset deassertion SHALL be synchronised internally to aclk.

Configuration
REQ-028 Macro AXIS_ARB_TIMEOUT_EN defined: a watchdog counter SHALL count GRANT cycles with no accepted beat, clear on any accepted beat, and at TIMEOUT_CYC release the grant as in REQ-020 without incrementing pkt_cnt, pulse timeout_err for one cycle and advance rr_ptr.
REQ-029 On a tlast beat and watchdog expiry at the same edge, the tlast beat SHALL win: normal release, no timeout_err.
REQ-030 Macro undefined: no watchdog logic SHALL be synthesised, timeout_err SHALL be constant 0 and a grant SHALL be held indefinitely.

Structure
REQ-031 Package axis_arb_pkg SHALL hold NUM_SRC=3, the GID_W=2 width, the GID_NONE=3 constant and the state enum {IDLE, GRANT}.
REQ-032 Sub-module axis_arb_rr_pick SHALL be purely combinational: given eligible[2:0] and rr_ptr, it returns next id and a valid bit.

Verification
REQ-033 Reset release with s_req=3'b111 -> s0_en high one cycle later; after each 4-beat packet the grant order is 1, 2, 0.
REQ-034 src_mask=3'b010 with s_req=3'b111 -> grant order 0, 2, 0, 2; source 1 never enabled.
REQ-035 force_en=1, force_sel=2 asserted during a source-0 packet -> source 0 finishes its packet, then after a 1-cycle gap s2_en high, even with s_req=0.
REQ-036 Source 1 granted, m_tready held low 10 cycles, then tlast beat accepted -> s1_en held throughout, pkt_cnt1 = 1, next grant after a 1-cycle IDLE gap.
REQ-037 With AXIS_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: granted source stalls 8 cycles -> timeout_err 1-cycle pulse, enables 0, pkt_cnt unchanged; tlast beat on the 8th cycle -> no pulse.
REQ-038 aresetn pulsed low mid-packet on source 2 -> all enables 0 within the same cycle, counters 0, source 0 granted first after release.
